// File: rtl/pr_en.sv
// Registered 4:1 select-and-capture stage with select-change pulse.
// Optional even-parity output enabled by defining PR_EN_PARITY_EN.
module pr_en #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       sel,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [1:0]       sel_q,
    output logic             sel_chg
`ifdef PR_EN_PARITY_EN
    ,
    output logic             out_par
`endif
);

    logic [WIDTH-1:0] mux_data;
    logic             captured;

    // NOTE: assign a value before the case so no path leaves mux_data unassigned (no latch).
    always_comb begin
        mux_data = a;
        case (sel)
            2'd0: mux_data = a;
            2'd1: mux_data = b;
            2'd2: mux_data = c;
            2'd3: mux_data = d;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            sel_q     <= 2'd0;
            out_valid <= 1'b0;
            sel_chg   <= 1'b0;
            captured  <= 1'b0;
        end else begin
            out_valid <= en;
            // The first capture after reset has no previous select to differ from.
            sel_chg   <= en && captured && (sel != sel_q);
            if (en) begin
                out      <= mux_data;
                sel_q    <= sel;
                captured <= 1'b1;
            end
        end
    end

`ifdef PR_EN_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            out_par <= 1'b0;
        end else if (en) begin
            out_par <= ^mux_data;
        end
    end
`endif

endmodule

// File: tb/tb_pr_en.sv
// Scoreboard bench for pr_en: driver pushes expected captures, monitor pops and compares.
// Parity checks are compiled in when PR_EN_PARITY_EN is defined.
module tb_pr_en;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] a = '0, b = '0, c = '0, d = '0;
    logic [1:0]   sel = 2'd0;
    logic         en = 1'b1;
    logic [W-1:0] out;
    logic         out_valid;
    logic [1:0]   sel_q;
    logic         sel_chg;
`ifdef PR_EN_PARITY_EN
    logic         out_par;
`endif

    pr_en #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
        .sel(sel), .en(en), .out(out), .out_valid(out_valid),
        .sel_q(sel_q), .sel_chg(sel_chg)
`ifdef PR_EN_PARITY_EN
        , .out_par(out_par)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic [1:0]   sel;
        logic         chg;
        logic         par;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: spec-level "has anything been captured" and last captured select.
    bit       m_captured = 1'b0;
    bit [1:0] m_sel = 2'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [1:0] s,
                         input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [W-1:0] vc, input logic [W-1:0] vd);
        logic [W-1:0] src[4];
        exp_t it;
        @(negedge clk);
        rst = r; en = e; sel = s; a = va; b = vb; c = vc; d = vd;
        src[0] = va; src[1] = vb; src[2] = vc; src[3] = vd;
        if (r) begin
            m_captured = 1'b0;
            m_sel      = 2'd0;
        end else if (e) begin
            it.data = src[s];
            it.sel  = s;
            it.chg  = m_captured && (s != m_sel);
            it.par  = ^src[s];
            q.push_back(it);
            m_captured = 1'b1;
            m_sel      = s;
        end
        // Disturb data and select between edges; outputs must not react.
        @(posedge clk);
        #2;
        a = W'($urandom); b = W'($urandom); c = W'($urandom); d = W'($urandom);
        sel = 2'($urandom);
    endtask

    // Monitor: samples 1 time unit after each edge, while rst/en still hold their sampled values.
    initial begin
        logic [W-1:0] hold_out;
        logic [1:0]   hold_sel;
        logic         hold_par;
        logic         exp_v;
        exp_t         it;
        hold_out = '0; hold_sel = 2'd0; hold_par = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            exp_v = !rst && en;
            check("out_valid", 32'(out_valid), 32'(exp_v));
            if (rst) begin
                hold_out = '0; hold_sel = 2'd0; hold_par = 1'b0;
                check("rst_out", 32'(out), 32'h0);
                check("rst_sel_q", 32'(sel_q), 32'h0);
                check("rst_sel_chg", 32'(sel_chg), 32'h0);
`ifdef PR_EN_PARITY_EN
                check("rst_out_par", 32'(out_par), 32'h0);
`endif
            end else if (exp_v) begin
                if (q.size() == 0) begin
                    check("scoreboard_underflow", 32'(q.size()), 32'h1);
                end else begin
                    it = q.pop_front();
                    check("out", 32'(out), 32'(it.data));
                    check("sel_q", 32'(sel_q), 32'(it.sel));
                    check("sel_chg", 32'(sel_chg), 32'(it.chg));
`ifdef PR_EN_PARITY_EN
                    check("out_par", 32'(out_par), 32'(it.par));
`endif
                    hold_out = it.data; hold_sel = it.sel; hold_par = it.par;
                end
            end else begin
                check("hold_out", 32'(out), 32'(hold_out));
                check("hold_sel_q", 32'(sel_q), 32'(hold_sel));
                check("hold_sel_chg", 32'(sel_chg), 32'h0);
`ifdef PR_EN_PARITY_EN
                check("hold_out_par", 32'(out_par), 32'(hold_par));
`endif
            end
            #3;
            check("stable_out", 32'(out), 32'(hold_out));
            check("stable_sel_q", 32'(sel_q), 32'(hold_sel));
        end
    end

    initial begin
        // Reset for two edges with arbitrary inputs.
        drive(1, 1, 2'd3, 8'h5C, 8'hE1, 8'h3D, 8'h77);
        drive(1, 0, 2'd1, 8'h12, 8'h34, 8'h56, 8'h78);
        // Select sweep: expected sel_chg 0,1,1,1.
        for (int i = 0; i < 4; i++)
            drive(0, 1, 2'(i), 8'h24, 8'h81, 8'h09, 8'h63);
        // Hold: capture c, then disabled with sel=3 and d=FF.
        drive(0, 1, 2'd2, 8'h24, 8'h81, 8'h09, 8'h63);
        drive(0, 0, 2'd3, 8'h24, 8'h81, 8'h09, 8'hFF);
        drive(0, 0, 2'd0, 8'h11, 8'h81, 8'h09, 8'hFF);
        // Same select twice with b changing.
        drive(0, 1, 2'd1, 8'h24, 8'h81, 8'h09, 8'h63);
        drive(0, 1, 2'd1, 8'h24, 8'h5A, 8'h09, 8'h63);
        // Parity values.
        drive(0, 1, 2'd0, 8'h81, 8'h00, 8'h00, 8'h00);
        drive(0, 1, 2'd0, 8'h83, 8'h00, 8'h00, 8'h00);
        // Reset wins over enable; the next capture must not flag a select change.
        drive(1, 1, 2'd0, 8'hAA, 8'h00, 8'h00, 8'h00);
        drive(0, 1, 2'd3, 8'h00, 8'h00, 8'h00, 8'hC3);
        drive(0, 1, 2'd0, 8'h3C, 8'h00, 8'h00, 8'hC3);
        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++)
            drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7), 2'($urandom),
                  W'($urandom), W'($urandom), W'($urandom), W'($urandom));
        drive(0, 0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00);
        drive(0, 0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        check("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pr_en.md
PR_EN -- requirements
Module: pr_en

Interface
REQ-001 Parameter WIDTH, default 8, data width of every data input and of out.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 a  input  WIDTH  data source 0.
REQ-005 b  input  WIDTH  data source 1.
REQ-006 c  input  WIDTH  data source 2.
REQ-007 d  input  WIDTH  data source 3.
REQ-008 sel  input  2  source select: 0=a, 1=b, 2=c, 3=d.
REQ-009 en  input  1  capture enable.
REQ-010 out  output  WIDTH  registered selected data.
REQ-011 out_valid  output  1  high for the cycle after a capture.
REQ-012 sel_q  output  2  select value used for the current out.
REQ-013 sel_chg  output  1  one-cycle pulse when a capture used a different sel than the previous capture.
REQ-014 out_par  output  1  even parity of out; present only when PR_EN_PARITY_EN is defined.

Function
REQ-015 On a rising edge with rst=0 and en=1: out SHALL load the source chosen by sel, sel_q SHALL load sel, and out_valid SHALL be 1.
REQ-016 Latency SHALL be exactly one clock: inputs sampled at edge N appear on out after edge N.
REQ-017 On a rising edge with rst=0 and en=0: out and sel_q SHALL hold, and out_valid and sel_chg SHALL be 0.
REQ-018 sel_chg SHALL be 1 after a capture only if sel differs from sel_q and at least one capture has occurred since reset; otherwise it SHALL be 0.
REQ-019 Changes on a, b, c, d or sel between edges SHALL have no effect on any output.
REQ-020 The mux SHALL be fully decoded; all four sel codes are legal and there is no default or X propagation path.
REQ-021 out SHALL be a pure copy of the selected source, with no arithmetic, truncation or extension.
REQ-022 All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.

Reset
REQ-023 While rst=1 at an edge: out=0, sel_q=0, out_valid=0, sel_chg=0, out_par=0, and the internal "captured since reset" flag SHALL clear.
REQ-024 rst SHALL take priority over en.
REQ-025 A reset asserted mid-operation SHALL discard the pending capture.
REQ-026 The first capture after reset SHALL never assert sel_chg.

Configuration
REQ-027 Macro PR_EN_PARITY_EN defined: out_par SHALL exist, register the XOR-reduction of the data loaded into out, be updated and held together with out, and be 0 on reset.
REQ-028 Macro PR_EN_PARITY_EN undefined: the out_par port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-029 Reset: rst=1 for 2 edges with arbitrary inputs -> out=0x00, sel_q=0, out_valid=0, sel_chg=0.
REQ-030 Select sweep: a=0x24, b=0x81, c=0x09, d=0x63, en=1, sel=0,1,2,3 on successive edges -> out=0x24, 0x81, 0x09, 0x63 one cycle later each, and sel_chg=0,1,1,1.
REQ-031 Hold: capture sel=2 (out=0x09), then en=0 with sel=3 and d=0xFF -> out stays 0x09, out_valid=0.
REQ-032 Same select: two consecutive captures with sel=1 and b changed 0x81->0x5A -> out=0x5A, sel_chg=0 on the second capture.
REQ-033 Reset priority: rst=1 and en=1 on the same edge with a=0xAA, sel=0 -> out=0x00, out_valid=0.
REQ-034 Parity (macro defined): capture 0x81 -> out_par=0; capture 0x83 -> out_par=1.
